// File: rtl/mem_wait_ctrl_if.sv
// Request/done bus for mem_wait_ctrl.
// The master issues mem_read/mem_write with address, write data and byte
// enables; the slave answers with ready, a one-cycle done pulse and data_out.
// With MEM_ALIGN_CHECK_EN defined the bus also carries the misaligned flag.
interface mem_wait_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   byte_en;
    logic [DATA_W-1:0]     data_out;
    logic                  ready;
    logic                  done;
`ifdef MEM_ALIGN_CHECK_EN
    logic                  misaligned;

    modport master (
        output mem_read, mem_write, address, data_in, byte_en,
        input  data_out, ready, done, misaligned
    );

    modport slave (
        input  mem_read, mem_write, address, data_in, byte_en,
        output data_out, ready, done, misaligned
    );
`else
    modport master (
        output mem_read, mem_write, address, data_in, byte_en,
        input  data_out, ready, done
    );

    modport slave (
        input  mem_read, mem_write, address, data_in, byte_en,
        output data_out, ready, done
    );
`endif
endinterface

// File: rtl/mem_wait_ctrl.sv
// Word-organised synchronous data memory with configurable wait states,
// byte-lane write enables and a busy (ready=0) indication.
// One request at a time: IDLE accepts, WAIT burns WAIT cycles, ACCESS does
// the RAM operation and pulses done. Requests seen while busy are dropped.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- flags requests whose
// address[1:0] is non-zero, skips their wait states and suppresses the access.
module mem_wait_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int WAIT   = 2
) (
    input logic            clk,
    input logic            rst_n,
    mem_wait_ctrl_if.slave bus
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam int         BE_W      = DATA_W / 8;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT > 0) ? (WAIT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    // Request latched at the accept edge; only meaningful while busy.
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              is_wr_q, is_wr_d;
    logic              mis_q, mis_d;

    logic              accept;
    logic              req_mis;
    logic              ram_we;
    logic [DATA_W-1:0] mem [DEPTH];

    // High address bits wrap the word index; low two bits only feed the check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[ADDR_W-1:IDX_W+2], bus.address[1:0]};

    assign accept = (state_q == S_IDLE) && (bus.mem_read || bus.mem_write);

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    assign req_mis        = (bus.address[1:0] != 2'b00);
    assign bus.misaligned = misaligned_q;
`else
    assign req_mis = 1'b0;
`endif

    // Next-state, request capture and access control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_wr_d    = is_wr_q;
        mis_d      = mis_q;
        ram_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d   = bus.address[IDX_W+1:2];
                    wdata_d = bus.data_in;
                    be_d    = bus.byte_en;
                    is_wr_d = bus.mem_write;      // write wins over read
                    mis_d   = req_mis;
                    if (req_mis || (WAIT == 0)) begin
                        state_d = S_ACCESS;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!mis_q) begin
                    if (is_wr_q) begin
                        ram_we = 1'b1;
                    end else begin
                        data_out_d = mem[idx_q];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned flag pulses alongside done for a flagged request.
    always_comb begin
        misaligned_d = (state_q == S_ACCESS) && mis_q;
    end

    // Misaligned flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`endif

    // Control state and registered outputs; reset aborts any pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    // Latched request fields; no reset needed, only read after an accept.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        is_wr_q <= is_wr_d;
        mis_q   <= mis_d;
    end

    // RAM write port, one enable per byte lane.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = (state_q == S_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: one instance with WAIT=2, one with WAIT=0.
module tb_mem_wait_ctrl;
    localparam int W2 = 0;
    localparam int W0 = 1;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    mem_wait_ctrl_if #(.DATA_W(32), .ADDR_W(32)) i2 ();
    mem_wait_ctrl_if #(.DATA_W(32), .ADDR_W(32)) i0 ();

    mem_wait_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT(2)) u_w2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i2.slave)
    );

    mem_wait_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT(0)) u_w0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (sel == W2) begin
            i2.mem_read = rd; i2.mem_write = wr; i2.address = a; i2.data_in = d; i2.byte_en = be;
        end else begin
            i0.mem_read = rd; i0.mem_write = wr; i0.address = a; i0.data_in = d; i0.byte_en = be;
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == W2) ? i2.done : i0.done;
    endfunction

    function automatic logic [31:0] get_dout(input int sel);
        return (sel == W2) ? i2.data_out : i0.data_out;
    endfunction

    // Present a request for one rising edge; returns #1 after the accept edge.
    task automatic issue(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        drive(sel, rd, wr, a, d, be);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, a, d, be);
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        while (get_done(sel) !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int extra;

        rst_n = 1'b0;
        drive(W2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(W0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_dout", i2.data_out, 32'h0);
        check("rst_ready", i2.ready, 1'b1);
        check("rst_done", i2.done, 1'b0);
        check("rst_ready_w0", i0.ready, 1'b1);
        rst_n = 1'b1;

        // Preload word 5
        issue(W2, 1'b0, 1'b1, 32'h14, 32'h55555555, 4'hF);
        wait_done(W2, cyc);
        check("w5_latency", cyc, 3);

        // Write 0xDEADBEEF to 0x10, watch ready/done cycle by cycle
        issue(W2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("wr_ready_c1", i2.ready, 1'b0);
        @(posedge clk); #1;
        check("wr_ready_c2", i2.ready, 1'b0);
        @(posedge clk); #1;
        check("wr_ready_c3", i2.ready, 1'b0);
        check("wr_done_c3", i2.done, 1'b0);
        @(posedge clk); #1;
        check("wr_done", i2.done, 1'b1);
        check("wr_ready_back", i2.ready, 1'b1);
        check("wr_dout_hold", i2.data_out, 32'h0);

        issue(W2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_done(W2, cyc);
        check("rd_latency", cyc, 3);
        check("rd_deadbeef", i2.data_out, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("done_one_cycle", i2.done, 1'b0);

        // Byte lanes
        issue(W2, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        wait_done(W2, cyc);
        issue(W2, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
        wait_done(W2, cyc);
        issue(W2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_done(W2, cyc);
        check("byte_lanes", i2.data_out, 32'h11BB33DD);

        // Address wrap
        issue(W2, 1'b0, 1'b1, 32'h400, 32'hCAFE0001, 4'hF);
        wait_done(W2, cyc);
        issue(W2, 1'b1, 1'b0, 32'h000, 32'h0, 4'h0);
        wait_done(W2, cyc);
        check("wrap_read", i2.data_out, 32'hCAFE0001);

        // Read+write together: write wins, data_out untouched
        issue(W2, 1'b1, 1'b1, 32'h20, 32'h99887766, 4'h5);
        wait_done(W2, cyc);
        check("prio_done", cyc, 3);
        check("prio_dout_hold", i2.data_out, 32'hCAFE0001);
        issue(W2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_done(W2, cyc);
        check("prio_written", i2.data_out, 32'h11883366);

        // byte_en=0 write completes, RAM unchanged
        issue(W2, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        wait_done(W2, cyc);
        check("be0_done", cyc, 3);
        issue(W2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_done(W2, cyc);
        check("be0_unchanged", i2.data_out, 32'h11883366);

        // Request while busy is ignored
        issue(W2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(W2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(posedge clk); #1;
        drive(W2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        wait_done(W2, cyc);
        check("busy_latency", cyc, 2);
        check("busy_dout", i2.data_out, 32'hDEADBEEF);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (i2.done === 1'b1) extra++;
        end
        check("busy_no_extra_done", extra, 0);

        // Reset mid-WAIT of a write to word 5
        issue(W2, 1'b0, 1'b1, 32'h14, 32'h0BADF00D, 4'hF);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", i2.data_out, 32'h0);
        check("midrst_ready", i2.ready, 1'b1);
        check("midrst_done", i2.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (i2.done === 1'b1) extra++;
        end
        check("midrst_no_done", extra, 0);
        issue(W2, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        wait_done(W2, cyc);
        check("midrst_old_data", i2.data_out, 32'h55555555);

        // WAIT=0 instance: single write latency and back-to-back reads
        issue(W0, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF);
        wait_done(W0, cyc);
        check("w0_latency", cyc, 1);
        @(negedge clk);
        drive(W0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("w0_b2b_done_%0d", k), get_done(W0), (k % 2) == 1);
        end
        drive(W0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("w0_b2b_dout", get_dout(W0), 32'hA5A5A5A5);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned write to 0x13: flagged, skips waits, word 4 untouched
        issue(W2, 1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF);
        check("mis_pre", i2.misaligned, 1'b0);
        @(posedge clk); #1;
        check("mis_flag", i2.misaligned, 1'b1);
        check("mis_done", i2.done, 1'b1);
        @(posedge clk); #1;
        check("mis_flag_clear", i2.misaligned, 1'b0);
        issue(W2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_done(W2, cyc);
        check("mis_word4", i2.data_out, 32'hDEADBEEF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
